// File: rtl/serial_link_ctrl.sv
// Full-duplex framed serial link: parametrised TX/RX FSMs, first-word fall-through
// RX FIFO and sticky receive error flags.
module serial_link_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CLKS   = 16,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  KEY,
  input  logic                  transEn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] parallelDataOut,
  output logic                  dataOut,
  output logic                  charSent,
  output logic                  txBusy,
  input  logic                  dataIn,
  output logic [DATA_WIDTH-1:0] parallelDataIn,
  output logic                  rxValid,
  input  logic                  rxRead,
  output logic                  charReceived,
  input  logic                  errClear,
  output logic                  parityError,
  output logic                  framingError,
  output logic                  rxOverflow
);
  localparam int CW = $clog2(BIT_CLKS);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------- transmitter ----------------
  logic [2:0]            tx_state;
  logic [CW-1:0]         tx_cnt;
  logic [IW-1:0]         tx_idx;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic                  tx_par;
  logic                  tx_go;

  assign tx_go    = transEn & load;
  assign charSent = (tx_state == S_STOP) && (tx_cnt == BIT_LAST) && (tx_idx == STOP_LAST);
  assign txBusy   = (tx_state != S_IDLE);

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else if (tx_state == S_IDLE) begin
      if (tx_go) begin
        tx_sh    <= parallelDataOut;
        tx_par   <= ^parallelDataOut;
        tx_cnt   <= '0;
        tx_idx   <= '0;
        tx_state <= S_START;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_idx   <= '0;
          end
          S_DATA: begin
            tx_sh <= tx_sh >> 1;
            if (tx_idx == DATA_LAST) begin
              tx_idx   <= '0;
              tx_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              tx_idx <= tx_idx + 1'b1;
            end
          end
          S_PARITY: tx_state <= S_STOP;
          default: begin
            if (tx_idx == STOP_LAST) begin
              tx_idx <= '0;
              // Capturing in the final stop cycle keeps back-to-back frames gapless.
              if (tx_go) begin
                tx_sh    <= parallelDataOut;
                tx_par   <= ^parallelDataOut;
                tx_state <= S_START;
              end else begin
                tx_state <= S_IDLE;
              end
            end else begin
              tx_idx <= tx_idx + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    dataOut = 1'b1;
    case (tx_state)
      S_START:  dataOut = 1'b0;
      S_DATA:   dataOut = tx_sh[0];
      S_PARITY: dataOut = tx_par;
      default:  dataOut = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic [1:0]            rx_sync;
  logic                  rx_s, rx_d;
  logic [2:0]            rx_state;
  logic [CW-1:0]         rx_cnt;
  logic [IW-1:0]         rx_idx;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  par_bad, stop_bad, rx_done;

  assign rx_s = rx_sync[1];

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      rx_sync  <= 2'b11;
      rx_d     <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
      rx_done  <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], dataIn};
      rx_d    <= rx_s;
      rx_done <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_d && !rx_s) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            // After the mid-start check, every later sample is one full bit apart.
            if (rx_s) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
              rx_cnt   <= '0;
              rx_idx   <= '0;
              par_bad  <= 1'b0;
              stop_bad <= 1'b0;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            case (rx_state)
              S_DATA: begin
                rx_sh <= {rx_s, rx_sh[DATA_WIDTH-1:1]};
                if (rx_idx == DATA_LAST) begin
                  rx_idx   <= '0;
                  rx_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                  rx_idx <= rx_idx + 1'b1;
                end
              end
              S_PARITY: begin
                par_bad  <= rx_s ^ (^rx_sh);
                rx_state <= S_STOP;
              end
              default: begin
                if (!rx_s) stop_bad <= 1'b1;
                if (rx_idx == STOP_LAST) begin
                  rx_idx   <= '0;
                  rx_state <= S_IDLE;
                  rx_done  <= 1'b1;
                end else begin
                  rx_idx <= rx_idx + 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- RX FIFO and flags ----------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  empty, full, pop, push, frame_ok, ovf_set;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rxRead & ~empty;
  assign frame_ok = rx_done & ~par_bad & ~stop_bad;
  assign push     = frame_ok & (~full | pop);
  assign ovf_set  = frame_ok & full & ~pop;

  assign rxValid        = ~empty;
  assign parallelDataIn = mem[rd_ptr[AW-1:0]];
  assign charReceived   = push;

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= rx_sh;
        wr_ptr              <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      parityError  <= 1'b0;
      framingError <= 1'b0;
      rxOverflow   <= 1'b0;
    end else begin
      parityError  <= (rx_done & par_bad) | (parityError & ~errClear);
      framingError <= (rx_done & ~par_bad & stop_bad) | (framingError & ~errClear);
      rxOverflow   <= ovf_set | (rxOverflow & ~errClear);
    end
  end
endmodule

// File: tb/tb_serial_link_ctrl.sv
// Scoreboarded bench for serial_link_ctrl: default, even-parity and two-stop-bit
// instances, with loopback and hand-built frames on dataIn.
module tb_serial_link_ctrl;
  logic clk = 1'b0;
  logic KEY;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // default instance (d_), parity instance (p_), two-stop instance (s_)
  logic       d_transEn, d_load, d_dataOut, d_charSent, d_txBusy, d_dataIn, d_rxValid, d_rxRead;
  logic       d_charReceived, d_errClear, d_parityError, d_framingError, d_rxOverflow;
  logic [7:0] d_pdo, d_pdi;
  logic       d_lb, d_line;
  logic       p_transEn, p_load, p_dataOut, p_charSent, p_txBusy, p_rxValid, p_rxRead;
  logic       p_charReceived, p_errClear, p_parityError, p_framingError, p_rxOverflow;
  logic [7:0] p_pdo, p_pdi;
  logic       p_line;
  logic       s_transEn, s_load, s_dataOut, s_charSent, s_txBusy, s_rxValid, s_rxRead;
  logic       s_charReceived, s_errClear, s_parityError, s_framingError, s_rxOverflow;
  logic [7:0] s_pdo, s_pdi;

  assign d_dataIn = d_lb ? d_dataOut : d_line;

  serial_link_ctrl u_def (
    .CLOCK_50(clk), .KEY(KEY), .transEn(d_transEn), .load(d_load), .parallelDataOut(d_pdo),
    .dataOut(d_dataOut), .charSent(d_charSent), .txBusy(d_txBusy), .dataIn(d_dataIn),
    .parallelDataIn(d_pdi), .rxValid(d_rxValid), .rxRead(d_rxRead), .charReceived(d_charReceived),
    .errClear(d_errClear), .parityError(d_parityError), .framingError(d_framingError),
    .rxOverflow(d_rxOverflow));

  serial_link_ctrl #(.PARITY_EN(1)) u_par (
    .CLOCK_50(clk), .KEY(KEY), .transEn(p_transEn), .load(p_load), .parallelDataOut(p_pdo),
    .dataOut(p_dataOut), .charSent(p_charSent), .txBusy(p_txBusy), .dataIn(p_line),
    .parallelDataIn(p_pdi), .rxValid(p_rxValid), .rxRead(p_rxRead), .charReceived(p_charReceived),
    .errClear(p_errClear), .parityError(p_parityError), .framingError(p_framingError),
    .rxOverflow(p_rxOverflow));

  serial_link_ctrl #(.STOP_BITS(2)) u_s2 (
    .CLOCK_50(clk), .KEY(KEY), .transEn(s_transEn), .load(s_load), .parallelDataOut(s_pdo),
    .dataOut(s_dataOut), .charSent(s_charSent), .txBusy(s_txBusy), .dataIn(s_dataOut),
    .parallelDataIn(s_pdi), .rxValid(s_rxValid), .rxRead(s_rxRead), .charReceived(s_charReceived),
    .errClear(s_errClear), .parityError(s_parityError), .framingError(s_framingError),
    .rxOverflow(s_rxOverflow));

  // scoreboard queues and monitors
  logic [7:0] exp_d[$], exp_p[$], exp_s[$];
  int d_sent = 0, d_sent_cyc = 0, d_rcv = 0, p_rcv = 0, s_rcv = 0;
  int s_sent_q[$];

  always @(negedge clk) begin
    if (KEY) begin
      if (d_charSent) begin d_sent++; d_sent_cyc = cyc; end
      if (s_charSent) s_sent_q.push_back(cyc);
      if (d_charReceived) d_rcv++;
      if (p_charReceived) p_rcv++;
      if (s_charReceived) s_rcv++;
      if (d_rxValid && d_rxRead) begin
        if (exp_d.size() == 0) check("def_unexpected_pop", {24'd0, d_pdi}, 32'hFFFF_FFFF);
        else check("def_rx_data", {24'd0, d_pdi}, {24'd0, exp_d.pop_front()});
      end
      if (p_rxValid && p_rxRead) begin
        if (exp_p.size() == 0) check("par_unexpected_pop", {24'd0, p_pdi}, 32'hFFFF_FFFF);
        else check("par_rx_data", {24'd0, p_pdi}, {24'd0, exp_p.pop_front()});
      end
      if (s_rxValid && s_rxRead) begin
        if (exp_s.size() == 0) check("s2_unexpected_pop", {24'd0, s_pdi}, 32'hFFFF_FFFF);
        else check("s2_rx_data", {24'd0, s_pdi}, {24'd0, exp_s.pop_front()});
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_sent(input int which, input int target);
    int k = 0;
    while (((which == 0) ? d_sent : s_sent_q.size()) < target && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("charSent_wait", {31'd0, k < 600}, 32'd1);
  endtask

  task automatic pop(input int which);
    case (which)
      0: d_rxRead = 1'b1;
      1: p_rxRead = 1'b1;
      default: s_rxRead = 1'b1;
    endcase
    settle(1);
    d_rxRead = 1'b0; p_rxRead = 1'b0; s_rxRead = 1'b0;
  endtask

  task automatic send_def(input logic [7:0] data);
    int target;
    target = d_sent + 1;
    d_pdo = data; d_load = 1'b1;
    settle(1);
    d_load = 1'b0;
    wait_sent(0, target);
    settle(1);
  endtask

  // drives n frame bits LSB first onto a bench-owned line, BIT_CLKS=16 each
  task automatic send_bits(input int which, input logic [19:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) d_line = bits[i]; else p_line = bits[i];
      settle(16);
    end
    d_line = 1'b1; p_line = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, base;
    logic [9:0] seq;
    KEY = 1'b0;
    d_transEn = 0; d_load = 0; d_pdo = 0; d_rxRead = 0; d_errClear = 0; d_lb = 1; d_line = 1;
    p_transEn = 0; p_load = 0; p_pdo = 0; p_rxRead = 0; p_errClear = 0; p_line = 1;
    s_transEn = 0; s_load = 0; s_pdo = 0; s_rxRead = 0; s_errClear = 0;
    settle(3);
    // 1: reset state
    check("rst_dataOut", {31'd0, d_dataOut}, 32'd1);
    check("rst_charSent", {31'd0, d_charSent}, 32'd0);
    check("rst_txBusy", {31'd0, d_txBusy}, 32'd0);
    check("rst_rxValid", {31'd0, d_rxValid}, 32'd0);
    check("rst_flags", {29'd0, d_parityError, d_framingError, d_rxOverflow}, 32'd0);
    check("rst_pdi", {24'd0, d_pdi}, 32'd0);
    KEY = 1'b1;
    settle(2);

    // 2: loopback 8'h72, exact bit sequence and timing
    d_transEn = 1'b1;
    d_pdo = 8'h72; d_load = 1'b1;
    exp_d.push_back(8'h72);
    settle(1);
    d_load = 1'b0;
    d_pdo = 8'hFF;
    t0 = cyc;
    seq = 10'b10_1110_0100;  // stop, 0x72 MSB..LSB, start
    for (int b = 0; b < 10; b++) begin
      wait_cyc(t0 + 16 * b + 8);
      check($sformatf("lb_bit%0d", b), {31'd0, d_dataOut}, {31'd0, seq[b]});
      if (b == 5) check("lb_txBusy", {31'd0, d_txBusy}, 32'd1);
    end
    wait_sent(0, 1);
    check("lb_charSent_offset", d_sent_cyc - t0, 32'd159);
    settle(1);
    check("lb_txBusy_done", {31'd0, d_txBusy}, 32'd0);
    settle(30);
    check("lb_charReceived", d_rcv, 32'd1);
    check("lb_rxValid", {31'd0, d_rxValid}, 32'd1);
    pop(0);
    check("lb_rxValid_after_pop", {31'd0, d_rxValid}, 32'd0);

    // 4: overflow with 5 frames into a 4-deep FIFO
    base = d_rcv;
    for (int i = 1; i <= 5; i++) begin
      send_def(8'(i));
      if (i <= 4) exp_d.push_back(8'(i));
    end
    settle(30);
    check("ovf_pushes", d_rcv - base, 32'd4);
    check("ovf_flag", {31'd0, d_rxOverflow}, 32'd1);
    check("ovf_no_frame_err", {30'd0, d_parityError, d_framingError}, 32'd0);
    for (int i = 0; i < 4; i++) pop(0);
    check("ovf_drained", {31'd0, d_rxValid}, 32'd0);
    d_errClear = 1'b1; settle(1); d_errClear = 1'b0;
    check("ovf_cleared", {31'd0, d_rxOverflow}, 32'd0);

    // 5: glitch rejection, then a framing error
    d_lb = 1'b0;
    base = d_rcv;
    d_line = 1'b0; settle(3); d_line = 1'b1;
    settle(40);
    check("glitch_rxValid", {31'd0, d_rxValid}, 32'd0);
    check("glitch_flags", {29'd0, d_parityError, d_framingError, d_rxOverflow}, 32'd0);
    check("glitch_no_push", d_rcv - base, 32'd0);
    send_bits(0, 20'({1'b0, 8'h55, 1'b0}), 10);
    settle(4);
    check("frm_flag", {31'd0, d_framingError}, 32'd1);
    check("frm_no_push", d_rcv - base, 32'd0);
    check("frm_rxValid", {31'd0, d_rxValid}, 32'd0);
    d_errClear = 1'b1; settle(1); d_errClear = 1'b0;
    check("frm_cleared", {31'd0, d_framingError}, 32'd0);

    // 3: parity instance, 0x07 with parity forced to 0, then a good 0x03
    send_bits(1, 20'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
    settle(4);
    check("par_flag", {31'd0, p_parityError}, 32'd1);
    check("par_no_push", p_rcv, 32'd0);
    check("par_rxValid", {31'd0, p_rxValid}, 32'd0);
    p_errClear = 1'b1; settle(1); p_errClear = 1'b0;
    check("par_cleared", {31'd0, p_parityError}, 32'd0);
    exp_p.push_back(8'h03);
    send_bits(1, 20'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
    settle(4);
    check("par_good_push", p_rcv, 32'd1);
    check("par_good_flags", {29'd0, p_parityError, p_framingError, p_rxOverflow}, 32'd0);
    pop(1);

    // 6: two stop bits, load held high, gapless back-to-back frames
    s_transEn = 1'b1;
    s_pdo = 8'hA5; s_load = 1'b1;
    exp_s.push_back(8'hA5);
    exp_s.push_back(8'h3C);
    settle(1);
    t0 = cyc;
    s_pdo = 8'h3C;
    wait_sent(1, 1);
    settle(1);
    s_load = 1'b0;
    @(negedge clk);
    check("b2b_no_gap", {31'd0, s_dataOut}, 32'd0);
    check("b2b_busy", {31'd0, s_txBusy}, 32'd1);
    wait_cyc(t0 + 176 + 16 + 8);
    check("b2b_frame2_bit0", {31'd0, s_dataOut}, 32'd0);
    wait_sent(1, 2);
    if (s_sent_q.size() >= 2) begin
      check("b2b_sent0_offset", s_sent_q[0] - t0, 32'd175);
      check("b2b_sent_spacing", s_sent_q[1] - s_sent_q[0], 32'd176);
    end
    settle(40);
    check("b2b_sent_count", s_sent_q.size(), 32'd2);
    check("b2b_pushes", s_rcv, 32'd2);
    pop(2);
    pop(2);
    check("b2b_drained", {31'd0, s_rxValid}, 32'd0);

    check("sb_def_empty", exp_d.size(), 32'd0);
    check("sb_par_empty", exp_p.size(), 32'd0);
    check("sb_s2_empty", exp_s.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
